// File: rtl/register_writeback_pkg.sv
// td4_pkg: shared TD4 opcodes, selector codes and datapath width
package td4_pkg;
  localparam int DATA_W = 4;
  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;
  localparam logic [1:0] SEL_REG_A = 2'b00;
  localparam logic [1:0] SEL_REG_B = 2'b01;
  localparam logic [1:0] SEL_SW    = 2'b10;
  localparam logic [1:0] SEL_ZERO  = 2'b11;
endpackage

// File: rtl/register_writeback_if.sv
// register_writeback_if: retire inputs (IN_EN/IN_OP/IN_ALU/IN_CARRY) and selector/state outputs
interface register_writeback_if;
  import td4_pkg::*;
  logic              IN_EN;
  logic [3:0]        IN_OP;
  logic [DATA_W-1:0] IN_ALU;
  logic              IN_CARRY;
  logic              SEL_A;
  logic              SEL_B;
  logic [DATA_W-1:0] OUT_A;
  logic [DATA_W-1:0] OUT_B;
  logic [DATA_W-1:0] OUT_PORT;
  logic [DATA_W-1:0] OUT_PC;
  logic              OUT_CF;
  modport master (output IN_EN, IN_OP, IN_ALU, IN_CARRY,
                  input SEL_A, SEL_B, OUT_A, OUT_B, OUT_PORT, OUT_PC, OUT_CF);
  modport slave  (input IN_EN, IN_OP, IN_ALU, IN_CARRY,
                  output SEL_A, SEL_B, OUT_A, OUT_B, OUT_PORT, OUT_PC, OUT_CF);
endinterface

// File: rtl/register_writeback_op_decoder.sv
// td4_op_decoder: opcode+CF in; selector code and LOAD_A/LOAD_B/LOAD_PORT/LOAD_PC (taken jump) out
module td4_op_decoder
  import td4_pkg::*;
(
  input  logic [3:0] IN_OP,
  input  logic       CF,
  output logic [1:0] SEL,
  output logic       LOAD_A,
  output logic       LOAD_B,
  output logic       LOAD_PORT,
  output logic       LOAD_PC
);
  always_comb begin
    SEL = SEL_ZERO;
    case (IN_OP)
      OP_ADD_A, OP_MOV_BA:           SEL = SEL_REG_A;
      OP_ADD_B, OP_MOV_AB, OP_OUT_B: SEL = SEL_REG_B;
      OP_IN_A, OP_IN_B:              SEL = SEL_SW;
      default:                       SEL = SEL_ZERO;
    endcase
  end
  assign LOAD_A    = IN_OP inside {OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_A};
  assign LOAD_B    = IN_OP inside {OP_ADD_B, OP_MOV_BA, OP_IN_B, OP_MOV_B};
  assign LOAD_PORT = IN_OP inside {OP_OUT_B, OP_OUT_IM};
  assign LOAD_PC   = (IN_OP == OP_JMP) || ((IN_OP == OP_JNC) && !CF);
endmodule

// File: rtl/register_writeback.sv
// register_writeback: CLK/RST plus slave bus; decodes IN_OP into SEL_A/SEL_B and retires IN_ALU into A/B/PORT/PC, IN_CARRY into CF
module register_writeback
  import td4_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  register_writeback_if.slave  bus
);
  logic [DATA_W-1:0] a, b, port, pc;
  logic              cf;
  logic [1:0]        sel;
  logic              load_a, load_b, load_port, load_pc;
  td4_op_decoder u_dec (
    .IN_OP     (bus.IN_OP),
    .CF        (cf),
    .SEL       (sel),
    .LOAD_A    (load_a),
    .LOAD_B    (load_b),
    .LOAD_PORT (load_port),
    .LOAD_PC   (load_pc)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      a    <= '0;
      b    <= '0;
      port <= '0;
      pc   <= '0;
      cf   <= 1'b0;
    end else if (bus.IN_EN) begin
      if (load_a) a <= bus.IN_ALU;
      if (load_b) b <= bus.IN_ALU;
      if (load_port) port <= bus.IN_ALU;
      pc <= load_pc ? bus.IN_ALU : pc + 1'b1;
      cf <= bus.IN_CARRY;
    end
  end
  assign {bus.SEL_B, bus.SEL_A} = sel;
  assign bus.OUT_A    = a;
  assign bus.OUT_B    = b;
  assign bus.OUT_PORT = port;
  assign bus.OUT_PC   = pc;
  assign bus.OUT_CF   = cf;
endmodule
